// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter / fetch request sequencer.
//
// Issues one fetch request per cycle while running and advances the PC by 4
// on every accepted fetch. Branch, jump and exception redirects can land at
// any time: they are applied on an accept, held in a pending register while
// the request is stalled, or loaded straight into the PC while not issuing.
//
// Build option: define PC_SEQ_ALIGN_CHECK_EN to send misaligned redirect
// targets to EXC_VECTOR and flag them on misalign_o. Without the macro,
// bits [1:0] of every target are cleared and misalign_o is tied low.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   halt_i         request to stop issuing fetches
//   br_valid_i     taken-branch redirect, target br_target_i
//   jmp_valid_i    jump redirect, target jmp_target_i
//   exc_valid_i    exception redirect to EXC_VECTOR
//   fetch_ready_i  instruction memory accepts the request this cycle
//   fetch_valid_o  fetch request valid
//   fetch_pc_o     fetch address (current PC)
//   pc_plus4_o     fetch_pc_o + 4, modulo 2^32
//   fetch_count_o  accepted fetches, wraps at 16 bits
//   misalign_o     one-cycle pulse after a misaligned redirect is taken
//
// state      | meaning
// RESET_HOLD | single idle cycle after reset release, no request
// ISSUE      | fetch request driven on fetch_valid_o / fetch_pc_o
// HALT       | stopped; PC held, redirects load it directly

module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt_i,
   input  logic        br_valid_i,
   input  logic [31:0] br_target_i,
   input  logic        jmp_valid_i,
   input  logic [31:0] jmp_target_i,
   input  logic        exc_valid_i,
   input  logic        fetch_ready_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [15:0] fetch_count_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {
      RESET_HOLD = 2'd0,
      ISSUE      = 2'd1,
      HALT       = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic        pend_q, pend_d;
   logic        halt_pend_q, halt_pend_d;
   logic [15:0] cnt_q;
   logic        accept;

   logic        redir_live;
   logic [31:0] redir_raw;
   logic [31:0] redir_tgt;

   assign fetch_pc_o    = pc_q;
   assign pc_plus4_o    = pc_q + 32'd4;
   assign fetch_count_o = cnt_q;

   // Redirect winner: exception over jump over branch.
   always_comb begin
      redir_live = exc_valid_i | jmp_valid_i | br_valid_i;
      redir_raw  = '0;
      if (exc_valid_i)
         redir_raw = EXC_VECTOR;
      else if (jmp_valid_i)
         redir_raw = jmp_target_i;
      else if (br_valid_i)
         redir_raw = br_target_i;
   end

`ifdef PC_SEQ_ALIGN_CHECK_EN
   logic redir_bad;
   logic misalign_q;

   assign redir_bad  = redir_live && (redir_raw[1:0] != 2'b00);
   assign redir_tgt  = redir_bad ? EXC_VECTOR : redir_raw;
   assign misalign_o = misalign_q;

   // Every live redirect is taken in the cycle it appears (applied, latched
   // as pending, or loaded while idle), so the flag simply follows it.
   always_ff @(posedge clk) begin
      if (!rst_n)
         misalign_q <= 1'b0;
      else
         misalign_q <= redir_bad;
   end
`else
   assign redir_tgt  = redir_raw & 32'hFFFF_FFFC;
   assign misalign_o = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_tgt_d    = pend_tgt_q;
      pend_d        = pend_q;
      halt_pend_d   = halt_pend_q;
      fetch_valid_o = 1'b0;
      accept        = 1'b0;
      case (state_q)
         RESET_HOLD: begin
            state_d = halt_i ? HALT : ISSUE;
            if (redir_live) begin
               pc_d   = redir_tgt;
               pend_d = 1'b0;
            end
         end
         ISSUE: begin
            fetch_valid_o = 1'b1;
            accept        = fetch_ready_i;
            if (accept) begin
               if (redir_live)
                  pc_d = redir_tgt;
               else if (pend_q)
                  pc_d = pend_tgt_q;
               else
                  pc_d = pc_plus4_o;
               pend_d      = 1'b0;
               halt_pend_d = 1'b0;
               if (halt_i || halt_pend_q)
                  state_d = HALT;
            end else begin
               // Request must stay stable while stalled; remember what
               // arrived and act on it at the accept.
               if (redir_live) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = redir_tgt;
               end
               if (halt_i)
                  halt_pend_d = 1'b1;
            end
         end
         HALT: begin
            if (redir_live) begin
               pc_d   = redir_tgt;
               pend_d = 1'b0;
            end
            if (!halt_i)
               state_d = ISSUE;
         end
         default: state_d = RESET_HOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RESET_HOLD;
         pc_q        <= RESET_PC;
         pend_tgt_q  <= '0;
         pend_q      <= 1'b0;
         halt_pend_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_tgt_q  <= pend_tgt_d;
         pend_q      <= pend_d;
         halt_pend_q <= halt_pend_d;
         if (accept)
            cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (default parameters).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        halt_i;
   logic        br_valid_i;
   logic [31:0] br_target_i;
   logic        jmp_valid_i;
   logic [31:0] jmp_target_i;
   logic        exc_valid_i;
   logic        fetch_ready_i;
   logic        fetch_valid_o;
   logic [31:0] fetch_pc_o;
   logic [31:0] pc_plus4_o;
   logic [15:0] fetch_count_o;
   logic        misalign_o;

   int n_tests = 0;
   int n_fail  = 0;

   pc_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .halt_i       (halt_i),
      .br_valid_i   (br_valid_i),
      .br_target_i  (br_target_i),
      .jmp_valid_i  (jmp_valid_i),
      .jmp_target_i (jmp_target_i),
      .exc_valid_i  (exc_valid_i),
      .fetch_ready_i(fetch_ready_i),
      .fetch_valid_o(fetch_valid_o),
      .fetch_pc_o   (fetch_pc_o),
      .pc_plus4_o   (pc_plus4_o),
      .fetch_count_o(fetch_count_o),
      .misalign_o   (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic v, input logic [31:0] pc,
                            input logic [15:0] cnt);
      check({tag, " valid"}, {31'd0, fetch_valid_o}, {31'd0, v});
      check({tag, " pc"}, fetch_pc_o, pc);
      check({tag, " count"}, {16'd0, fetch_count_o}, {16'd0, cnt});
   endtask

   task automatic clr_redir();
      br_valid_i  = 1'b0;
      jmp_valid_i = 1'b0;
      exc_valid_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; halt_i = 1'b0; fetch_ready_i = 1'b1;
      br_valid_i = 1'b0; br_target_i = '0;
      jmp_valid_i = 1'b0; jmp_target_i = '0; exc_valid_i = 1'b0;
      tick(); tick();
      chk_state("reset", 1'b0, 32'h0, 16'd0);
      check("reset misalign", {31'd0, misalign_o}, 32'd0);

      // Reset release with ready held high
      rst_n = 1'b1;
      chk_state("hold", 1'b0, 32'h0, 16'd0);
      tick(); chk_state("seq0", 1'b1, 32'h0, 16'd0);
      check("plus4", pc_plus4_o, 32'h4);
      tick(); chk_state("seq1", 1'b1, 32'h4, 16'd1);
      tick(); chk_state("seq2", 1'b1, 32'h8, 16'd2);
      tick(); chk_state("seq3", 1'b1, 32'hC, 16'd3);

      // Stall three cycles, branch to 0x100 arrives during the stall
      fetch_ready_i = 1'b0;
      tick(); chk_state("stall1", 1'b1, 32'hC, 16'd3);
      br_valid_i = 1'b1; br_target_i = 32'h100;
      tick(); chk_state("stall2", 1'b1, 32'hC, 16'd3);
      clr_redir();
      tick(); chk_state("stall3", 1'b1, 32'hC, 16'd3);
      fetch_ready_i = 1'b1;
      tick(); chk_state("pending", 1'b1, 32'h100, 16'd4);

      // All three redirects together: exception wins
      exc_valid_i = 1'b1;
      jmp_valid_i = 1'b1; jmp_target_i = 32'h40;
      br_valid_i  = 1'b1; br_target_i  = 32'h80;
      tick(); chk_state("prio", 1'b1, 32'h8000_0180, 16'd5);
      clr_redir();

      // Jump to 0x20, then halt on the accept there
      jmp_valid_i = 1'b1; jmp_target_i = 32'h20;
      tick(); chk_state("jmp20", 1'b1, 32'h20, 16'd6);
      clr_redir();
      halt_i = 1'b1;
      tick(); chk_state("halt", 1'b0, 32'h24, 16'd7);
      jmp_valid_i = 1'b1; jmp_target_i = 32'h200;
      tick(); chk_state("halt jmp", 1'b0, 32'h200, 16'd7);
      clr_redir();
      tick(); chk_state("halt hold", 1'b0, 32'h200, 16'd7);
      halt_i = 1'b0;
      tick(); chk_state("unhalt", 1'b1, 32'h200, 16'd7);

      // Halt raised during a stall takes effect at the next accept
      fetch_ready_i = 1'b0; halt_i = 1'b1;
      tick(); chk_state("halt stall", 1'b1, 32'h200, 16'd7);
      halt_i = 1'b0; fetch_ready_i = 1'b1;
      tick(); chk_state("late halt", 1'b0, 32'h204, 16'd8);
      tick(); chk_state("late resume", 1'b1, 32'h204, 16'd8);

      // Wrap of the PC
      jmp_valid_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC;
      tick(); chk_state("top", 1'b1, 32'hFFFF_FFFC, 16'd9);
      clr_redir();
      check("plus4 wrap", pc_plus4_o, 32'h0);
      tick(); chk_state("wrap", 1'b1, 32'h0, 16'd10);

      // Misaligned branch target
      br_valid_i = 1'b1; br_target_i = 32'h102;
      tick();
      clr_redir();
`ifdef PC_SEQ_ALIGN_CHECK_EN
      chk_state("mis", 1'b1, 32'h8000_0180, 16'd11);
      check("mis pulse", {31'd0, misalign_o}, 32'd1);
      tick();
      check("mis clear", {31'd0, misalign_o}, 32'd0);
`else
      chk_state("mis", 1'b1, 32'h100, 16'd11);
      check("mis pulse", {31'd0, misalign_o}, 32'd0);
      tick();
      check("mis clear", {31'd0, misalign_o}, 32'd0);
`endif

      // Reset while a request is outstanding drops it
      fetch_ready_i = 1'b0; rst_n = 1'b0;
      tick(); chk_state("rst drop", 1'b0, 32'h0, 16'd0);
      rst_n = 1'b1;
      fetch_ready_i = 1'b1;
      // Redirect during the hold cycle loads the PC directly
      jmp_valid_i = 1'b1; jmp_target_i = 32'h300;
      tick(); chk_state("hold jmp", 1'b1, 32'h300, 16'd0);
      clr_redir();

      // Counter wrap after 65536 accepts
      for (int i = 0; i < 65535; i++) tick();
      check("cnt ffff", {16'd0, fetch_count_o}, 32'h0000_FFFF);
      tick();
      chk_state("cnt wrap", 1'b1, 32'h0004_0300, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h8000_0180, is the exception redirect target.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 halt_i  input  1  request to stop issuing fetches.
REQ-006 br_valid_i / br_target_i  input  1 / 32  taken-branch redirect and its target.
REQ-007 jmp_valid_i / jmp_target_i  input  1 / 32  jump redirect and its target.
REQ-008 exc_valid_i  input  1  exception redirect to EXC_VECTOR.
REQ-009 fetch_valid_o  output  1  fetch request valid.
REQ-010 fetch_pc_o  output  32  fetch address; current PC register.
REQ-011 fetch_ready_i  input  1  instruction memory accepts the request this cycle.
REQ-012 pc_plus4_o  output  32  fetch_pc_o + 4, combinational, modulo 2^32.
REQ-013 fetch_count_o  output  16  count of accepted fetches, wraps 16'hFFFF -> 0.
REQ-014 misalign_o  output  1  one-cycle pulse on a misaligned redirect target.

Function
REQ-015 States RESET_HOLD, ISSUE and HALT; fetch_valid_o SHALL be 1 only in ISSUE.
REQ-016 RESET_HOLD SHALL last exactly one cycle after rst_n deasserts, then go to ISSUE (to HALT if halt_i=1).
REQ-017 A fetch is accepted on a cycle with fetch_valid_o=1 and fetch_ready_i=1; fetch_count_o increments by 1 on each accept.
REQ-018 While fetch_valid_o=1 and fetch_ready_i=0, fetch_pc_o SHALL hold stable and fetch_valid_o SHALL stay 1; halt_i and redirects SHALL NOT withdraw the request.
REQ-019 Live redirect priority: exc_valid_i > jmp_valid_i > br_valid_i; only the winner is used.
REQ-020 On accept, next PC = live redirect target if any, else pending target if pending, else pc_plus4_o; the pending flag clears on accept.
REQ-021 A live redirect on a non-accept cycle in ISSUE SHALL be latched into a pending register (target plus flag), overwriting any earlier pending target.
REQ-022 In RESET_HOLD or HALT, a live redirect SHALL load the PC directly on the next edge and clear pending.
REQ-023 ISSUE -> HALT on an accept cycle with halt_i=1; halt_i on a non-accept cycle SHALL take effect at the next accept.
REQ-024 HALT -> ISSUE on the first cycle with halt_i=0; the PC at exit is the value held, including any redirect loaded in HALT.
REQ-025 PC arithmetic SHALL be 32-bit unsigned; 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.

Reset
REQ-026 With rst_n=0 on an edge: state=RESET_HOLD, PC=RESET_PC, pending flag cleared, fetch_count_o=0, misalign_o=0.
REQ-027 Reset SHALL take priority over all inputs, including reset asserted with a request outstanding; the request is dropped without acceptance.

Configuration
REQ-028 Macro PC_SEQ_ALIGN_CHECK_EN: when defined, a winning redirect target with bits[1:0] != 0 SHALL be replaced by EXC_VECTOR, and misalign_o SHALL pulse 1 on the cycle after the redirect is taken (applied or latched).
REQ-029 When PC_SEQ_ALIGN_CHECK_EN is undefined, bits[1:0] of every redirect target SHALL be forced to 2'b00, and misalign_o SHALL be tied to 0.

Verification
REQ-030 Reset release, fetch_ready_i=1 constant -> one cycle valid=0, then fetch_pc_o = 0, 4, 8, 12 on consecutive cycles; fetch_count_o = 1, 2, 3.
REQ-031 fetch_ready_i=0 for 3 cycles with br_valid_i pulse (target 0x100) in cycle 2 -> fetch_pc_o stable for all 3 cycles; after accept, next fetch_pc_o = 0x100.
REQ-032 exc_valid_i, jmp_valid_i (0x40) and br_valid_i (0x80) together on an accept -> next fetch_pc_o = 0x8000_0180.
REQ-033 halt_i=1 on an accept at PC 0x20 -> valid=0 from next cycle; jmp (0x200) during HALT; halt_i=0 -> fetch_pc_o = 0x200.
REQ-034 PC=0xFFFF_FFFC accepted -> next fetch_pc_o = 0x0; 65536 accepts from reset -> fetch_count_o = 0.
REQ-035 With PC_SEQ_ALIGN_CHECK_EN, br target 0x102 on an accept -> misalign_o=1 for one cycle, next PC 0x8000_0180; without the macro -> next PC 0x100, misalign_o=0.
